// File: rtl/ui_overlay_engine_if.sv
// ui_overlay_engine_if
//   Groups the overlay engine's bus signals: the slot-table write port, the
//   pixel scan input, and the pipelined lookup result.
//   master modport: drives slot writes and scan positions, receives results.
//   slave modport : the engine side.
//   Ports (all logic):
//     wr_en, wr_slot, wr_x, wr_y, wr_w, wr_h, wr_src_h, wr_src_v,
//     wr_enable, wr_blink, clear_all        -- slot table programming
//     pix_valid, h_cnt, v_cnt                -- scan position in
//     pixel_addr, isObject, obj_slot, out_valid -- lookup result out
interface ui_overlay_engine_if #(
  parameter int NUM_SLOTS = 8
) ();
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic              wr_en;
  logic [SLOT_W-1:0] wr_slot;
  logic [8:0]        wr_x;
  logic [8:0]        wr_y;
  logic [8:0]        wr_w;
  logic [8:0]        wr_h;
  logic [8:0]        wr_src_h;
  logic [8:0]        wr_src_v;
  logic              wr_enable;
  logic              wr_blink;
  logic              clear_all;

  logic              pix_valid;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;

  logic [16:0]       pixel_addr;
  logic              isObject;
  logic [SLOT_W-1:0] obj_slot;
  logic              out_valid;

  modport master (
    output wr_en, wr_slot, wr_x, wr_y, wr_w, wr_h, wr_src_h, wr_src_v,
           wr_enable, wr_blink, clear_all, pix_valid, h_cnt, v_cnt,
    input  pixel_addr, isObject, obj_slot, out_valid
  );

  modport slave (
    input  wr_en, wr_slot, wr_x, wr_y, wr_w, wr_h, wr_src_h, wr_src_v,
           wr_enable, wr_blink, clear_all, pix_valid, h_cnt, v_cnt,
    output pixel_addr, isObject, obj_slot, out_valid
  );
endinterface

// File: rtl/ui_overlay_engine.sv
// ui_overlay_engine
//   Overlays up to NUM_SLOTS programmable rectangles on a VGA scan. Each slot
//   maps a screen rectangle (in downscaled sheet coordinates) onto a region of
//   a sprite sheet. For every qualified pixel the engine reports whether an
//   enabled slot covers it, which slot wins (lowest index), and the sheet
//   address of the sprite pixel to show. Two-cycle latency, one pixel/cycle.
//   Ports:
//     clk  -- system clock
//     rst  -- synchronous active-high reset
//     bus  -- ui_overlay_engine_if.slave (slot writes, scan in, result out)
module ui_overlay_engine #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int NUM_SLOTS = 8,
  parameter int SHIFT     = 1,
  parameter int BLINK_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  ui_overlay_engine_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [19:0] FRAME_SIZE = 20'(IMG_W * IMG_H);

  // Slot table
  logic [8:0] slot_x     [NUM_SLOTS];
  logic [8:0] slot_y     [NUM_SLOTS];
  logic [8:0] slot_w     [NUM_SLOTS];
  logic [8:0] slot_h     [NUM_SLOTS];
  logic [8:0] slot_src_h [NUM_SLOTS];
  logic [8:0] slot_src_v [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_en;
  logic [NUM_SLOTS-1:0] slot_blink;

  logic [BLINK_W-1:0] blink_cnt;

  // Stage 1 signals
  logic [9:0]           pix_x;
  logic [9:0]           pix_y;
  logic [NUM_SLOTS-1:0] hit_c;
  logic [9:0]           col_c [NUM_SLOTS];
  logic [9:0]           row_c [NUM_SLOTS];
  logic                 s1_valid;
  logic [NUM_SLOTS-1:0] s1_hit;
  logic [9:0]           s1_col [NUM_SLOTS];
  logic [9:0]           s1_row [NUM_SLOTS];

  // Stage 2 signals
  logic              sel_found;
  logic [SLOT_W-1:0] sel_idx;
  logic [9:0]        sel_col;
  logic [9:0]        sel_row;
  logic [19:0]       raw_addr;
  logic [19:0]       wrap_addr;

  // Only the enable/blink bits need a reset; geometry is meaningless while
  // a slot is disabled. clear_all is applied after the write so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_en    <= '0;
      slot_blink <= '0;
    end else begin
      if (bus.wr_en) begin
        slot_en[bus.wr_slot]    <= bus.wr_enable;
        slot_blink[bus.wr_slot] <= bus.wr_blink;
      end
      if (bus.clear_all) begin
        slot_en <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      slot_x[bus.wr_slot]     <= bus.wr_x;
      slot_y[bus.wr_slot]     <= bus.wr_y;
      slot_w[bus.wr_slot]     <= bus.wr_w;
      slot_h[bus.wr_slot]     <= bus.wr_h;
      slot_src_h[bus.wr_slot] <= bus.wr_src_h;
      slot_src_v[bus.wr_slot] <= bus.wr_src_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  assign pix_x = 10'(bus.h_cnt >> SHIFT);
  assign pix_y = 10'(bus.v_cnt >> SHIFT);

  // Bounds are compared in 10 bits so slot_x+w cannot wrap; a zero width or
  // height makes the range empty. The offsets are only meaningful on a hit.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_c[i] = slot_en[i]
              && (!slot_blink[i] || !blink_cnt[BLINK_W-1])
              && (pix_x >= {1'b0, slot_x[i]})
              && (pix_x <  ({1'b0, slot_x[i]} + {1'b0, slot_w[i]}))
              && (pix_y >= {1'b0, slot_y[i]})
              && (pix_y <  ({1'b0, slot_y[i]} + {1'b0, slot_h[i]}));
      col_c[i] = {1'b0, slot_src_h[i]} + (pix_x - {1'b0, slot_x[i]});
      row_c[i] = {1'b0, slot_src_v[i]} + (pix_y - {1'b0, slot_y[i]});
    end
  end

  // Hit vector is forced to zero for unqualified pixels so stage 2 never
  // reports an object without a valid pixel behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_hit   <= bus.pix_valid ? hit_c : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      s1_col[i] <= col_c[i];
      s1_row[i] <= row_c[i];
    end
  end

  // Scanning from the top index down lets the lowest hitting slot win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_col   = '0;
    sel_row   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        sel_found = 1'b1;
        sel_idx   = SLOT_W'(i);
        sel_col   = s1_col[i];
        sel_row   = s1_row[i];
      end
    end
  end

  // Single wrap: an address past the end of the sheet folds back once.
  assign raw_addr  = 20'(sel_col) + 20'(sel_row) * 20'(IMG_W);
  assign wrap_addr = (raw_addr >= FRAME_SIZE) ? (raw_addr - FRAME_SIZE) : raw_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.isObject   <= 1'b0;
      bus.obj_slot   <= '0;
      bus.pixel_addr <= '0;
    end else begin
      bus.out_valid  <= s1_valid;
      bus.isObject   <= s1_valid && sel_found;
      bus.obj_slot   <= (s1_valid && sel_found) ? sel_idx : '0;
      bus.pixel_addr <= (s1_valid && sel_found) ? wrap_addr[16:0] : '0;
    end
  end
endmodule
